pattern_bank: RTL and testbench
===============================

PATTERN_BANK -- requirements
Module: pattern_bank

Interface
REQ-001 Parameters SHALL be: NUM_BUFS, default 8, number of pattern buffers (2..16); BUF_BYTES, default 22, bytes per buffer; BYTE_W, default 8, bits per byte.
REQ-002 Derived widths SHALL be: IW = clog2(NUM_BUFS); FW = clog2(BUF_BYTES).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 sin, ssel, sen  in  1 each  scan data, scan select, shift strobe (one clk cycle per bit).
REQ-006 saddr  in  IW  scan target buffer index.
REQ-007 sout  out  1  scan data out.
REQ-008 buf_sel  in  NUM_BUFS  requested active buffer, one-hot.
REQ-009 sel_req, frame_sync  in  1 each  switch request, frame boundary strobe.
REQ-010 sel_ack, sel_err  out  1 each  switch-done pulse, bad-select pulse.
REQ-011 cur_buf  out  BUF_BYTES*BYTE_W  active buffer contents; byte k at bits [k*BYTE_W +: BYTE_W].
REQ-012 bufp  in  NUM_BUFS  field buffer select, one-hot.
REQ-013 fieldp, fieldwp  in  FW each  read and write byte indices.
REQ-014 field_rd, field_write  in  1 each  read and write strobes.
REQ-015 field_in  in  BYTE_W  write data.
REQ-016 field_byte  out  BYTE_W; field_valid, field_err, wr_drop  out  1 each.

Function
REQ-017 Scan: on sen&&ssel, buffer saddr SHALL shift one bit toward the MSB of its flat vector, sin into bit 0; sout SHALL equal that buffer's MSB while ssel=1, else 0.
REQ-018 saddr >= NUM_BUFS SHALL suppress shifting and drive sout 0.
REQ-019 Field write: field_write with one-hot bufp and fieldwp < BUF_BYTES SHALL write field_in to that byte at the next edge.
REQ-020 A write whose target buffer is shifting the same cycle SHALL be dropped; wr_drop SHALL pulse 1 cycle.
REQ-021 Field read: field_rd SHALL register the selected byte; field_byte and field_valid SHALL appear exactly 1 cycle later; field_valid is a 1-cycle pulse.
REQ-022 A read or write with bufp not one-hot, or index >= BUF_BYTES, SHALL perform no write, return field_byte 0, and pulse field_err 1 cycle later.
REQ-023 A read and write of the same byte in the same cycle SHALL return the old data.
REQ-024 The switch FSM SHALL have states IDLE, PEND, ACK.
REQ-025 IDLE + sel_req + one-hot buf_sel: latch the index, go to PEND. IDLE + sel_req + non-one-hot buf_sel: pulse sel_err, stay in IDLE.
REQ-026 PEND + frame_sync: update the active index, go to ACK. sel_req in PEND SHALL overwrite the latched index if buf_sel is one-hot, else be ignored.
REQ-027 ACK: pulse sel_ack for 1 cycle, return to IDLE.
REQ-028 cur_buf SHALL be registered from the active buffer every cycle (1-cycle latency), so it reflects scan and field writes 1 cycle after they land.

Reset
REQ-029 rst SHALL asynchronously clear all buffers to 0, set the active index to 0, put the FSM in IDLE, and drive cur_buf, field_byte, sout and all pulse outputs to 0.
REQ-030 rst asserted mid-shift or mid-switch SHALL abandon the operation; no pending switch survives reset.

Configuration
REQ-031 Macro PATTERN_BANK_SCAN_EN defined: the scan chain SHALL behave per REQ-017/018.
REQ-032 Macro PATTERN_BANK_SCAN_EN undefined: sin, ssel, sen and saddr SHALL be ignored, sout SHALL be tied 0, no write is dropped, and buffers SHALL be loadable only by field writes.

Verification
REQ-033 Scan: with defaults, ssel=1, saddr=2, 176 sen pulses of pattern 0xA5 per byte -> every byte of buffer 2 reads 0xA5 and the other buffers read 0.
REQ-034 Field write: write 0x3C to bufp=8'b0000_0100, fieldwp=5 -> field_rd of the same location gives field_byte=0x3C with field_valid exactly 1 cycle after field_rd.
REQ-035 Switch: sel_req with buf_sel=8'b0000_1000, frame_sync 4 cycles later -> cur_buf shows buffer 3 contents; sel_ack pulses once, in the cycle after frame_sync.
REQ-036 Bad inputs: buf_sel=8'b0000_0110 -> sel_err pulse, active buffer unchanged; fieldp=22 -> field_err, field_byte=0.
REQ-037 Collision: field_write to buffer 1 while it shifts -> wr_drop=1 and the byte is unchanged.
REQ-038 Reset: rst asserted in PEND -> FSM in IDLE, cur_buf=0; no sel_ack after rst is released.

Source files
------------

// File: rtl/pattern_bank_if.sv
// pattern_bank_if: scan, switch and field-access signals of pattern_bank
interface pattern_bank_if #(
  parameter int NUM_BUFS  = 8,
  parameter int BUF_BYTES = 22,
  parameter int BYTE_W    = 8
);
  localparam int IW = $clog2(NUM_BUFS);
  localparam int FW = $clog2(BUF_BYTES);
  logic                        sin;
  logic                        ssel;
  logic                        sen;
  logic [IW-1:0]               saddr;
  logic                        sout;
  logic [NUM_BUFS-1:0]         buf_sel;
  logic                        sel_req;
  logic                        frame_sync;
  logic                        sel_ack;
  logic                        sel_err;
  logic [BUF_BYTES*BYTE_W-1:0] cur_buf;
  logic [NUM_BUFS-1:0]         bufp;
  logic [FW-1:0]               fieldp;
  logic [FW-1:0]               fieldwp;
  logic                        field_rd;
  logic                        field_write;
  logic [BYTE_W-1:0]           field_in;
  logic [BYTE_W-1:0]           field_byte;
  logic                        field_valid;
  logic                        field_err;
  logic                        wr_drop;
  modport master (
    output sin, ssel, sen, saddr, buf_sel, sel_req, frame_sync,
           bufp, fieldp, fieldwp, field_rd, field_write, field_in,
    input  sout, sel_ack, sel_err, cur_buf, field_byte, field_valid, field_err, wr_drop
  );
  modport slave (
    input  sin, ssel, sen, saddr, buf_sel, sel_req, frame_sync,
           bufp, fieldp, fieldwp, field_rd, field_write, field_in,
    output sout, sel_ack, sel_err, cur_buf, field_byte, field_valid, field_err, wr_drop
  );
endinterface

// File: rtl/pattern_bank.sv
// pattern_bank: bank of pattern buffers with byte field access, frame-synced active-buffer switch and optional scan chain (PATTERN_BANK_SCAN_EN)
module pattern_bank #(
  parameter int NUM_BUFS  = 8,
  parameter int BUF_BYTES = 22,
  parameter int BYTE_W    = 8
) (
  input logic           clk,
  input logic           rst,
  pattern_bank_if.slave bus
);
  localparam int IW = $clog2(NUM_BUFS);
  localparam int FW = $clog2(BUF_BYTES);
  localparam int BW = BUF_BYTES * BYTE_W;
  typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;
  function automatic logic [IW-1:0] to_idx(input logic [NUM_BUFS-1:0] oh);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_BUFS; i++) r = oh[i] ? IW'(i) : r;
    return r;
  endfunction
  logic [BW-1:0]     bufs [NUM_BUFS];
  logic [IW-1:0]     b_idx;
  logic              b_oh;
  logic              wr_in;
  logic              rd_in;
  logic              wr_ok;
  logic              rd_ok;
  logic              wr_hit;
  logic [BYTE_W-1:0] rd_byte;
  state_t            state;
  state_t            state_n;
  logic [IW-1:0]     pend_idx;
  logic [IW-1:0]     pend_n;
  logic [IW-1:0]     act_idx;
  logic [IW-1:0]     act_n;
  logic              sel_oh;
  logic              sel_err_n;
  assign b_oh  = $onehot(bus.bufp);
  assign b_idx = to_idx(bus.bufp);
  assign wr_in = {1'b0, bus.fieldwp} < (FW+1)'(BUF_BYTES);
  assign rd_in = {1'b0, bus.fieldp} < (FW+1)'(BUF_BYTES);
  assign wr_ok = bus.field_write && b_oh && wr_in;
  assign rd_ok = bus.field_rd && b_oh && rd_in;
`ifdef PATTERN_BANK_SCAN_EN
  logic scan_in_range;
  logic scan_on;
  logic shift_en;
  if (NUM_BUFS == (1 << IW)) begin : g_full
    assign scan_in_range = 1'b1;
  end else begin : g_part
    assign scan_in_range = {1'b0, bus.saddr} < (IW+1)'(NUM_BUFS);
  end
  assign scan_on  = bus.ssel && scan_in_range;
  assign shift_en = scan_on && bus.sen;
  assign bus.sout = scan_on && bufs[bus.saddr][BW-1];
  assign wr_hit   = wr_ok && shift_en && (bus.saddr == b_idx);
`else
  logic unused_scan;
  assign unused_scan = ^{bus.sin, bus.ssel, bus.sen, bus.saddr};
  assign bus.sout    = 1'b0;
  assign wr_hit      = 1'b0;
`endif
  // byte mux for field reads from the buffer addressed by bufp
  always_comb begin
    rd_byte = '0;
    for (int k = 0; k < BUF_BYTES; k++) rd_byte = (bus.fieldp == FW'(k)) ? bufs[b_idx][k*BYTE_W +: BYTE_W] : rd_byte;
  end
  // buffer storage: scan shift and field writes; a write colliding with a shift of the same buffer is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BUFS; i++) bufs[i] <= '0;
    end else begin
`ifdef PATTERN_BANK_SCAN_EN
      if (shift_en) bufs[bus.saddr] <= {bufs[bus.saddr][BW-2:0], bus.sin};
`endif
      if (wr_ok && !wr_hit)
        for (int k = 0; k < BUF_BYTES; k++)
          if (bus.fieldwp == FW'(k)) bufs[b_idx][k*BYTE_W +: BYTE_W] <= bus.field_in;
    end
  end
  // registered outputs: active buffer image, read data and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cur_buf     <= '0;
      bus.field_byte  <= '0;
      bus.field_valid <= 1'b0;
      bus.field_err   <= 1'b0;
      bus.wr_drop     <= 1'b0;
    end else begin
      bus.cur_buf     <= bufs[act_idx];
      bus.field_byte  <= bus.field_rd ? (rd_ok ? rd_byte : '0) : bus.field_byte;
      bus.field_valid <= rd_ok;
      bus.field_err   <= (bus.field_rd && !(b_oh && rd_in)) || (bus.field_write && !(b_oh && wr_in));
      bus.wr_drop     <= wr_hit;
    end
  end
  assign sel_oh      = $onehot(bus.buf_sel);
  assign bus.sel_ack = (state == ACK);
  // switch FSM next state: latch a one-hot request, commit it on frame_sync, acknowledge once
  always_comb begin
    state_n   = state;
    pend_n    = pend_idx;
    act_n     = act_idx;
    sel_err_n = 1'b0;
    case (state)
      IDLE: begin
        pend_n    = (bus.sel_req && sel_oh) ? to_idx(bus.buf_sel) : pend_idx;
        state_n   = (bus.sel_req && sel_oh) ? PEND : IDLE;
        sel_err_n = bus.sel_req && !sel_oh;
      end
      PEND: begin
        pend_n  = (bus.sel_req && sel_oh) ? to_idx(bus.buf_sel) : pend_idx;
        act_n   = bus.frame_sync ? pend_n : act_idx;
        state_n = bus.frame_sync ? ACK : PEND;
      end
      default: state_n = IDLE;
    endcase
  end
  // switch FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pend_idx    <= '0;
      act_idx     <= '0;
      bus.sel_err <= 1'b0;
    end else begin
      state       <= state_n;
      pend_idx    <= pend_n;
      act_idx     <= act_n;
      bus.sel_err <= sel_err_n;
    end
  end
endmodule

// File: tb/tb_pattern_bank.sv
// tb_pattern_bank: scoreboard bench for pattern_bank
module tb_pattern_bank;
  localparam int NB  = 8;
  localparam int BB  = 22;
  localparam int BYW = 8;
  localparam int BW  = BB * BYW;
`ifdef PATTERN_BANK_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [NB][BB];
  logic [7:0] sb [$];
  logic [7:0] pat;
  logic [BW-1:0] old;
  pattern_bank_if #(.NUM_BUFS(NB), .BUF_BYTES(BB), .BYTE_W(BYW)) bus ();
  pattern_bank #(.NUM_BUFS(NB), .BUF_BYTES(BB), .BYTE_W(BYW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [BW-1:0] flat(input int b);
    logic [BW-1:0] r;
    for (int k = 0; k < BB; k++) r[k*BYW +: BYW] = mdl[b][k];
    return r;
  endfunction
  task automatic access(input int b, input bit we, input int wi, input logic [7:0] wv, input bit re, input int ri);
    bus.bufp        = NB'(1) << b;
    bus.field_write = we;
    bus.fieldwp     = 5'(wi);
    bus.field_in    = wv;
    bus.field_rd    = re;
    bus.fieldp      = 5'(ri);
    if (re) sb.push_back(mdl[b][ri]);
    if (we) mdl[b][wi] = wv;
    tick;
    bus.field_write = 1'b0;
    bus.field_rd    = 1'b0;
    if (re) check("rd_valid", bus.field_valid, 1);
  endtask
  always @(negedge clk) begin
    if (!rst && bus.field_valid) begin
      if (sb.size() == 0) check("sb_spurious", 32'(sb.size()), 1);
      else check("rd_data", bus.field_byte, sb.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end
  initial begin
    bus.sin = 0; bus.ssel = 0; bus.sen = 0; bus.saddr = '0;
    bus.buf_sel = '0; bus.sel_req = 0; bus.frame_sync = 0;
    bus.bufp = '0; bus.fieldp = '0; bus.fieldwp = '0;
    bus.field_rd = 0; bus.field_write = 0; bus.field_in = '0;
    for (int b = 0; b < NB; b++) for (int k = 0; k < BB; k++) mdl[b][k] = 8'h00;
    #1 rst = 1'b1;
    #1;
    check("rst_cur_buf", bus.cur_buf, 0);
    check("rst_field_byte", bus.field_byte, 0);
    check("rst_sout", bus.sout, 0);
    check("rst_sel_ack", bus.sel_ack, 0);
    check("rst_sel_err", bus.sel_err, 0);
    check("rst_field_valid", bus.field_valid, 0);
    check("rst_field_err", bus.field_err, 0);
    check("rst_wr_drop", bus.wr_drop, 0);
    @(negedge clk) rst = 1'b0;
    tick;
    // scan load of buffer 2 with 0xA5 in every byte
    bus.ssel = 1; bus.saddr = 3'd2; pat = 8'hA5;
    for (int j = BW - 1; j >= 0; j--) begin
      bus.sin = pat[j % 8];
      bus.sen = 1;
      tick;
    end
    bus.sen = 0;
    if (SCAN) for (int k = 0; k < BB; k++) mdl[2][k] = 8'hA5;
    check("sout_msb", bus.sout, SCAN);
    bus.ssel = 0;
    #1 check("sout_nosel", bus.sout, 0);
    for (int k = 0; k < BB; k++) access(2, 0, 0, 8'h00, 1, k);
    access(0, 0, 0, 8'h00, 1, 0);
    access(1, 0, 0, 8'h00, 1, 10);
    access(7, 0, 0, 8'h00, 1, 21);
    // field write then read back, valid exactly one cycle later
    access(2, 1, 5, 8'h3C, 0, 0);
    access(2, 0, 0, 8'h00, 1, 5);
    check("rd_byte_3c", bus.field_byte, 8'h3C);
    tick;
    check("rd_valid_pulse", bus.field_valid, 0);
    for (int k = 0; k < BB; k++) access(3, 1, k, 8'($urandom_range(1, 255)), 0, 0);
    access(3, 1, 9, 8'h5A, 1, 9);
    access(3, 0, 0, 8'h00, 1, 9);
    access(3, 0, 0, 8'h00, 1, 0);
    access(3, 0, 0, 8'h00, 1, 21);
    // switch to buffer 3 with frame_sync four cycles after the request
    bus.buf_sel = 8'b0000_1000; bus.sel_req = 1;
    tick;
    bus.sel_req = 0;
    check("sel_err_ok", bus.sel_err, 0);
    repeat (3) tick;
    check("ack_pend", bus.sel_ack, 0);
    check("cur_buf_pre", bus.cur_buf, flat(0));
    bus.frame_sync = 1;
    tick;
    bus.frame_sync = 0;
    check("sel_ack_pulse", bus.sel_ack, 1);
    tick;
    check("sel_ack_once", bus.sel_ack, 0);
    check("cur_buf_sw", bus.cur_buf, flat(3));
    old = flat(3);
    access(3, 1, 7, 8'hE1, 0, 0);
    check("cur_buf_lag", bus.cur_buf, old);
    tick;
    check("cur_buf_upd", bus.cur_buf, flat(3));
    // non-one-hot switch request
    bus.buf_sel = 8'b0000_0110; bus.sel_req = 1;
    tick;
    bus.sel_req = 0;
    check("sel_err_pulse", bus.sel_err, 1);
    tick;
    check("sel_err_clr", bus.sel_err, 0);
    bus.frame_sync = 1;
    tick;
    bus.frame_sync = 0;
    check("no_ack_bad", bus.sel_ack, 0);
    tick;
    check("cur_buf_kept", bus.cur_buf, flat(3));
    // out-of-range and non-one-hot field accesses
    bus.bufp = 8'b0000_0100; bus.fieldp = 5'd22; bus.field_rd = 1;
    tick;
    bus.field_rd = 0;
    check("ferr_rd_idx", bus.field_err, 1);
    check("fbyte_zero", bus.field_byte, 0);
    check("fvalid_err", bus.field_valid, 0);
    bus.bufp = 8'b0000_0011; bus.fieldwp = 5'd0; bus.field_in = 8'hFF; bus.field_write = 1;
    tick;
    bus.field_write = 0;
    check("ferr_wr_bufp", bus.field_err, 1);
    bus.bufp = 8'b0000_1000; bus.fieldwp = 5'd22; bus.field_write = 1;
    tick;
    bus.field_write = 0;
    check("ferr_wr_idx", bus.field_err, 1);
    tick;
    check("ferr_clr", bus.field_err, 0);
    check("cur_buf_nowr", bus.cur_buf, flat(3));
    access(0, 0, 0, 8'h00, 1, 0);
    access(1, 0, 0, 8'h00, 1, 0);
    // field write colliding with a shift of the same buffer
    bus.ssel = 1; bus.saddr = 3'd1; bus.sen = 1; bus.sin = 0;
    bus.bufp = 8'b0000_0010; bus.fieldwp = 5'd4; bus.field_in = 8'h77; bus.field_write = 1;
    tick;
    bus.sen = 0; bus.ssel = 0; bus.field_write = 0;
    check("wr_drop", bus.wr_drop, SCAN);
    mdl[1][4] = SCAN ? 8'h00 : 8'h77;
    tick;
    check("wr_drop_clr", bus.wr_drop, 0);
    access(1, 0, 0, 8'h00, 1, 4);
    // reset while a switch is pending
    bus.buf_sel = 8'b0000_0001; bus.sel_req = 1;
    tick;
    bus.sel_req = 0;
    tick;
    #1 rst = 1'b1;
    #1;
    check("rst_pend_cur_buf", bus.cur_buf, 0);
    check("rst_pend_ack", bus.sel_ack, 0);
    for (int b = 0; b < NB; b++) for (int k = 0; k < BB; k++) mdl[b][k] = 8'h00;
    @(negedge clk) rst = 1'b0;
    bus.frame_sync = 1;
    tick;
    bus.frame_sync = 0;
    check("no_ack_after_rst", bus.sel_ack, 0);
    tick;
    check("no_ack_after_rst2", bus.sel_ack, 0);
    access(3, 0, 0, 8'h00, 1, 7);
    access(0, 1, 0, 8'h81, 0, 0);
    tick;
    check("cur_buf_act0", bus.cur_buf, flat(0));
    tick;
    check("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
